uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
Serial UART transmitter that sits directly upstream of the UART receiver. It accepts one parallel byte per handshake and serialises it LSB-first as a frame: start bit, 8 data bits, optional parity bit, stop bit. Each bit is held on the line for Prescale clock cycles, so the receiver's oversampling ratio matches the bit period. Its serial output drives the receiver's S_Data input directly.

Parameters:
DATA_WIDTH, 8, number of data bits per frame
PRESCALE_WIDTH, 5, width of the Prescale input

Ports:
CLK  input  1  system clock; all logic is rising-edge.
Reset  input  1  synchronous, active-high reset.
P_Data  input  DATA_WIDTH  parallel byte to transmit.
Data_valid  input  1  request to transmit P_Data; accepted only while busy=0.
Parity_EN  input  1  1 = insert a parity bit after the data bits.
Parity_type  input  1  0 = even parity, 1 = odd parity.
Prescale  input  PRESCALE_WIDTH  clock cycles per bit; 0 is treated as 1.
TX_OUT  output  1  serial line; idles high.
busy  output  1  high from the accept edge until the end of the stop bit.
Done  output  1  one-cycle pulse in the cycle after the stop bit completes.

Behaviour:
- Reset values (registered outputs): TX_OUT=1, busy=0, Done=0, FSM=IDLE, all counters 0.
- Reset mid-frame aborts the frame. After that edge: TX_OUT=1, busy=0, no Done pulse.
- FSM states and transitions:
  - IDLE: TX_OUT=1. On an edge with Data_valid=1, the block latches P_Data, Parity_EN, Parity_type and the effective Prescale (PS), then goes to START.
  - START: TX_OUT=0 for PS cycles, then DATA.
  - DATA: drives bit[idx], idx=0..7 (LSB first), PS cycles each. After idx=7 it goes to PARITY if the latched Parity_EN=1, else STOP.
  - PARITY: drives XOR of the latched byte, inverted when Parity_type=1, for PS cycles, then STOP.
  - STOP: TX_OUT=1 for PS cycles, then IDLE.
- Outputs are registered. TX_OUT changes on the accept edge (start bit appears on the edge that samples Data_valid) and at every PS-cycle boundary thereafter.
- Frame length: 11*PS cycles with parity, 10*PS without.
- busy goes 1 on the accept edge and 0 on the edge that enters IDLE. Done=1 for exactly that following cycle.
- Minimum gap: at least one IDLE cycle (TX_OUT=1) separates back-to-back frames. Data_valid held high continuously produces frames separated by exactly one cycle.
- Data_valid while busy=1 is ignored and is not queued.
- Changes to P_Data, Parity_EN, Parity_type or Prescale mid-frame have no effect on the frame in flight.
- Prescale counter: counts 0..PS-1 and wraps at each bit boundary. Bit index is 3 bits, DATA_WIDTH-1 max.
- PS=1: one bit per clock; a frame takes 11 cycles with parity.
- Prescale=31: 31 cycles per bit, no counter overflow.

Test Plan:
- Prescale=8, Parity_EN=1, Parity_type=0, P_Data=8'hAB, Data_valid pulse -> TX_OUT sequence 0,1,1,0,1,0,1,0,1,1,1, each held 8 cycles. busy high for 88 cycles; Done pulse once; TX_OUT=1 afterwards.
- P_Data=8'h00 with Parity_type=1 -> parity bit 1. Same byte with Parity_type=0 -> parity bit 0. Parity_EN=0, P_Data=8'h55 -> 10-bit frame 0,1,0,1,0,1,0,1,0,1, 80 cycles total.
- Prescale=0 and Prescale=1, P_Data=8'hFF, parity even -> 11-cycle frame 0,1,1,1,1,1,1,1,1,0,1.
- Data_valid held high, P_Data changed to 8'h3C mid-frame -> first frame still carries the original byte. Exactly one idle-high cycle follows, then the second frame carries 8'h3C.
- Reset asserted during the data bits of a Prescale=8 frame -> on the next edge TX_OUT=1, busy=0, Done=0. A new Data_valid afterwards produces a full, correct frame.
- Loopback: connect TX_OUT to the receiver's S_Data with Prescale=8 and send bytes 8'hA5, 8'h00, 8'hFF with even, odd and no parity -> receiver shows Data_valid=1, P_Data equal to each sent byte, Parity_error=0, stop_error=0.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: LSB-first UART serialiser with optional parity and per-bit prescale
module uart_tx #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 5
) (
    input  logic                      CLK,
    input  logic                      Reset,
    input  logic [DATA_WIDTH-1:0]     P_Data,
    input  logic                      Data_valid,
    input  logic                      Parity_EN,
    input  logic                      Parity_type,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic                      TX_OUT,
    output logic                      busy,
    output logic                      Done
);
    localparam int IW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                    state, state_n;
    logic [PRESCALE_WIDTH-1:0] cnt, cnt_n, ps, ps_n;
    logic [IW-1:0]             idx, idx_n;
    logic [DATA_WIDTH-1:0]     data, data_n;
    logic                      pen, pen_n, ptype, ptype_n, tx_n, bit_end;

    // Next state, frame parameters latched on accept, and the line value for the next cycle
    always_comb begin
        bit_end = cnt == ps - 1'b1;
        state_n = state;
        idx_n   = idx;
        data_n  = data;
        pen_n   = pen;
        ptype_n = ptype;
        ps_n    = ps;
        cnt_n   = (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
        case (state)
            IDLE: if (Data_valid) begin
                state_n = START;
                idx_n   = '0;
                data_n  = P_Data;
                pen_n   = Parity_EN;
                ptype_n = Parity_type;
                ps_n    = Prescale == '0 ? PRESCALE_WIDTH'(1) : Prescale;
            end
            START: if (bit_end) state_n = DATA;
            DATA: if (bit_end) begin
                idx_n = idx + 1'b1;
                if (idx == IW'(DATA_WIDTH - 1)) begin
                    idx_n   = '0;
                    state_n = pen ? PARITY : STOP;
                end
            end
            PARITY: if (bit_end) state_n = STOP;
            STOP: if (bit_end) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        tx_n = state_n == START  ? 1'b0 :
               state_n == DATA   ? data_n[idx_n] :
               state_n == PARITY ? ^data_n ^ ptype_n : 1'b1;
    end

    // State, counters and registered outputs; Done marks the return to IDLE
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            data   <= '0;
            pen    <= 1'b0;
            ptype  <= 1'b0;
            ps     <= '0;
            TX_OUT <= 1'b1;
            busy   <= 1'b0;
            Done   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            data   <= data_n;
            pen    <= pen_n;
            ptype  <= ptype_n;
            ps     <= ps_n;
            TX_OUT <= tx_n;
            busy   <= state_n != IDLE;
            Done   <= state == STOP && state_n == IDLE;
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: table, random and corner-sequence checks of the UART transmitter
module tb_uart_tx;
    logic       CLK = 1'b0, Reset = 1'b1, Data_valid = 1'b0, Parity_EN = 1'b0, Parity_type = 1'b0;
    logic [7:0] P_Data = '0;
    logic [4:0] Prescale = '0;
    logic       TX_OUT, busy, Done;
    int         errors = 0, checks = 0;

    uart_tx dut (
        .CLK(CLK), .Reset(Reset), .P_Data(P_Data), .Data_valid(Data_valid),
        .Parity_EN(Parity_EN), .Parity_type(Parity_type), .Prescale(Prescale),
        .TX_OUT(TX_OUT), .busy(busy), .Done(Done)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [7:0]  d;
        logic        pen;
        logic        pt;
        logic [4:0]  ps;
        logic [10:0] exp;
        int          n;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Frame as transmitted, bit i of the result is the i-th bit on the line
    function automatic logic [10:0] model(input logic [7:0] d, input logic pen, input logic pt);
        logic par;
        par = (($countones(d) % 2) == 1) ^ pt;
        return pen ? {1'b1, par, d, 1'b0} : {1'b0, 1'b1, d, 1'b0};
    endfunction

    task automatic start(input logic [7:0] d, input logic pen, input logic pt, input logic [4:0] ps, input bit hold);
        @(negedge CLK);
        P_Data = d; Parity_EN = pen; Parity_type = pt; Prescale = ps; Data_valid = 1'b1;
        @(posedge CLK);
        if (!hold) #1 Data_valid = 1'b0;
    endtask

    task automatic sample_frame(input logic [10:0] exp, input int n, input int pse, input bit noise);
        int busy_bad;
        busy_bad = 0;
        for (int i = 0; i < n; i++) begin
            logic got;
            got = exp[i];
            for (int j = 0; j < pse; j++) begin
                @(negedge CLK);
                if (noise) begin
                    Data_valid = 1'($urandom); P_Data = 8'($urandom);
                    Parity_EN = 1'($urandom); Parity_type = 1'($urandom); Prescale = 5'($urandom);
                end
                if (TX_OUT !== exp[i]) got = TX_OUT;
                if (busy !== 1'b1) busy_bad++;
            end
            chk($sformatf("bit%0d", i), 32'(got), 32'(exp[i]));
        end
        chk("busy_in_frame", 32'(busy_bad), 32'd0);
    endtask

    task automatic finish_checks();
        @(negedge CLK);
        Data_valid = 1'b0;
        chk("end_tx", 32'(TX_OUT), 32'd1);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_done", 32'(Done), 32'd1);
        @(negedge CLK);
        chk("done_pulse_len", 32'(Done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic run_frame(input logic [7:0] d, input logic pen, input logic pt, input logic [4:0] ps,
                             input logic [10:0] exp, input int n, input bit noise);
        start(d, pen, pt, ps, 1'b0);
        sample_frame(exp, n, ps == 0 ? 1 : int'(ps), noise);
        finish_checks();
    endtask

    task automatic rx(input int ps, input logic pen, input logic pt,
                      output logic [7:0] d, output logic perr, output logic serr, output bit found);
        logic par;
        found = 1'b0; d = '0; perr = 1'b1; serr = 1'b1;
        for (int k = 0; k < 400 && !found; k++) begin
            @(negedge CLK);
            if (TX_OUT === 1'b0) found = 1'b1;
        end
        if (found) begin
            repeat (ps / 2) @(negedge CLK);
            for (int i = 0; i < 8; i++) begin
                repeat (ps) @(negedge CLK);
                d[i] = TX_OUT;
            end
            perr = 1'b0;
            if (pen) begin
                repeat (ps) @(negedge CLK);
                par = TX_OUT;
                perr = par !== ((^d) ^ pt);
            end
            repeat (ps) @(negedge CLK);
            serr = TX_OUT !== 1'b1;
        end
    endtask

    initial begin
        logic [7:0]  rd, d;
        logic        perr, serr, pen, pt;
        logic [4:0]  ps;
        logic [10:0] e;
        bit          found;
        int          w;
        logic [7:0]  lb_d[3];
        logic        lb_pen[3], lb_pt[3];

        tbl[0] = '{8'hAB, 1'b1, 1'b0, 5'd8,  11'b1_1_10101011_0, 11};
        tbl[1] = '{8'h00, 1'b1, 1'b1, 5'd8,  11'b1_1_00000000_0, 11};
        tbl[2] = '{8'h00, 1'b1, 1'b0, 5'd4,  11'b1_0_00000000_0, 11};
        tbl[3] = '{8'h55, 1'b0, 1'b0, 5'd8,  11'b0_1_01010101_0, 10};
        tbl[4] = '{8'hFF, 1'b1, 1'b0, 5'd0,  11'b1_0_11111111_0, 11};
        tbl[5] = '{8'hFF, 1'b1, 1'b0, 5'd1,  11'b1_0_11111111_0, 11};
        tbl[6] = '{8'hA5, 1'b1, 1'b0, 5'd8,  11'b1_0_10100101_0, 11};
        tbl[7] = '{8'hA5, 1'b1, 1'b1, 5'd3,  11'b1_1_10100101_0, 11};
        tbl[8] = '{8'hFF, 1'b0, 1'b0, 5'd31, 11'b0_1_11111111_0, 10};

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_tx", 32'(TX_OUT), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(Done), 32'd0);
        Reset = 1'b0;

        for (int k = 0; k < 9; k++)
            run_frame(tbl[k].d, tbl[k].pen, tbl[k].pt, tbl[k].ps, tbl[k].exp, tbl[k].n, 1'b0);

        for (int k = 0; k < 25; k++) begin
            d = 8'($urandom); pen = 1'($urandom); pt = 1'($urandom);
            ps = 5'($urandom_range(0, 6));
            run_frame(d, pen, pt, ps, model(d, pen, pt), pen ? 11 : 10, 1'b1);
        end

        start(8'hC3, 1'b0, 1'b0, 5'd2, 1'b1);
        #1 P_Data = 8'h3C;
        sample_frame(11'b0_1_11000011_0, 10, 2, 1'b0);
        @(negedge CLK);
        chk("gap_tx", 32'(TX_OUT), 32'd1);
        chk("gap_busy", 32'(busy), 32'd0);
        chk("gap_done", 32'(Done), 32'd1);
        sample_frame(11'b0_1_00111100_0, 10, 2, 1'b0);
        finish_checks();

        start(8'hAB, 1'b1, 1'b0, 5'd8, 1'b0);
        repeat (30) @(negedge CLK);
        Reset = 1'b1;
        @(posedge CLK);
        #1;
        chk("abort_tx", 32'(TX_OUT), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(Done), 32'd0);
        @(negedge CLK);
        Reset = 1'b0;
        repeat (2) @(negedge CLK);
        chk("abort_no_done", 32'(Done), 32'd0);
        run_frame(8'hAB, 1'b1, 1'b0, 5'd8, 11'b1_1_10101011_0, 11, 1'b0);

        lb_d = '{8'hA5, 8'h00, 8'hFF};
        lb_pen = '{1'b1, 1'b1, 1'b0};
        lb_pt = '{1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            fork
                start(lb_d[k], lb_pen[k], lb_pt[k], 5'd8, 1'b0);
                rx(8, lb_pen[k], lb_pt[k], rd, perr, serr, found);
            join
            chk("lb_found", 32'(found), 32'd1);
            chk("lb_data", 32'(rd), 32'(lb_d[k]));
            chk("lb_parity_error", 32'(perr), 32'd0);
            chk("lb_stop_error", 32'(serr), 32'd0);
            w = 0;
            while (Done !== 1'b1 && w < 100) begin
                @(negedge CLK);
                w++;
            end
            chk("lb_done", 32'(Done), 32'd1);
            @(negedge CLK);
        end

        e = model(8'hAB, 1'b1, 1'b0);
        chk("model_vs_table", 32'(e), 32'(tbl[0].exp));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
